// File: rtl/setpoint_sequencer_pkg.sv
// Shared widths and FSM encoding for the setpoint sequencer.
package setpoint_sequencer_pkg;

  localparam int unsigned SP_W  = 12;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    S_MANUAL     = 2'd0,
    S_AUTO_RAMP  = 2'd1,
    S_AUTO_DWELL = 2'd2
  } state_t;

endpackage

// File: rtl/setpoint_sequencer_slew_limiter.sv
// Rate limiter: moves sp_out toward target_q by at most SLEW_STEP LSB every SLEW_DIV cycles.
module setpoint_sequencer_slew_limiter
  import setpoint_sequencer_pkg::*;
#(
  parameter int unsigned SLEW_DIV  = 1000,
  parameter int unsigned SLEW_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic [SP_W-1:0] target_q,
  output logic [SP_W-1:0] sp_out,
  output logic            at_target
);

  localparam int unsigned TICK_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int unsigned DIFF_W = SP_W + 1;

  logic [TICK_W-1:0] tick_q;
  logic              tick_term_c;
  logic [DIFF_W-1:0] diff_up_c;
  logic [DIFF_W-1:0] diff_dn_c;
  logic [DIFF_W-1:0] step_up_c;
  logic [DIFF_W-1:0] step_dn_c;

  assign tick_term_c = (tick_q == TICK_W'(SLEW_DIV - 1));

  // Step is clipped to the remaining distance so the ramp lands exactly on target.
  assign diff_up_c = DIFF_W'(target_q) - DIFF_W'(sp_out);
  assign diff_dn_c = DIFF_W'(sp_out) - DIFF_W'(target_q);
  assign step_up_c = (diff_up_c > DIFF_W'(SLEW_STEP)) ? DIFF_W'(SLEW_STEP) : diff_up_c;
  assign step_dn_c = (diff_dn_c > DIFF_W'(SLEW_STEP)) ? DIFF_W'(SLEW_STEP) : diff_dn_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= '0;
      sp_out <= '0;
    end else if (!hold) begin
      if (tick_term_c) begin
        tick_q <= '0;
        if (sp_out < target_q) begin
          sp_out <= sp_out + SP_W'(step_up_c);
        end else if (sp_out > target_q) begin
          sp_out <= sp_out - SP_W'(step_dn_c);
        end
      end else begin
        tick_q <= tick_q + TICK_W'(1);
      end
    end
  end

  assign at_target = (sp_out == target_q);

endmodule

// File: rtl/setpoint_sequencer.sv
// Setpoint mux controller: manual/auto select generation plus slew-limited setpoint output.
module setpoint_sequencer
  import setpoint_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SP       = 7,
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned SLEW_DIV     = 1000,
  parameter int unsigned SLEW_STEP    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             auto_en,
  input  logic             hold,
  input  logic [SP_W-1:0]  sp_mux,
  output logic [SEL_W-1:0] sel,
  output logic [SP_W-1:0]  sp_out,
  output logic             at_target,
  output logic             ramp_busy
);

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [SEL_W-1:0]   SEL_MAX    = SEL_W'(NUM_SP - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;
  logic [SP_W-1:0]    target_q;
  logic               dwell_done_c;

  // Mux readback latch; the loop target lags a select change by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
    end else begin
      target_q <= sp_mux;
    end
  end

  setpoint_sequencer_slew_limiter #(
    .SLEW_DIV  (SLEW_DIV),
    .SLEW_STEP (SLEW_STEP)
  ) slew_limiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .target_q  (target_q),
    .sp_out    (sp_out),
    .at_target (at_target)
  );

  assign ramp_busy = !at_target;

  assign dwell_done_c = (state_q == S_AUTO_DWELL) && at_target && !hold &&
                        (dwell_q == DWELL_LAST);

  // State, select and dwell registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_MANUAL;
      sel     <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!auto_en) begin
      state_d = S_MANUAL;
    end else begin
      case (state_q)
        S_MANUAL, S_AUTO_RAMP: state_d = at_target ? S_AUTO_DWELL : S_AUTO_RAMP;
        S_AUTO_DWELL: begin
          if (!at_target || dwell_done_c) begin
            state_d = S_AUTO_RAMP;
          end
        end
        default: state_d = S_MANUAL;
      endcase
    end
  end

  // Select and dwell counter updates for the current state.
  always_comb begin
    sel_d   = sel;
    dwell_d = dwell_q;
    case (state_q)
      S_MANUAL: begin
        dwell_d = '0;
        case ({btn_up, btn_down})
          2'b10:   if (sel < SEL_MAX) sel_d = sel + SEL_W'(1);
          2'b01:   if (sel != '0)     sel_d = sel - SEL_W'(1);
          default: sel_d = sel;
        endcase
      end
      S_AUTO_RAMP: dwell_d = '0;
      S_AUTO_DWELL: begin
        if (!at_target) begin
          dwell_d = '0;
        end else if (dwell_done_c) begin
          dwell_d = '0;
          sel_d   = (sel >= SEL_MAX) ? '0 : sel + SEL_W'(1);
        end else if (!hold) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: dwell_d = '0;
    endcase
    // Leaving auto mode restarts any future dwell from zero.
    if (!auto_en) begin
      dwell_d = '0;
    end
  end

endmodule

// File: doc/setpoint_sequencer.md
Name: setpoint_sequencer

Overview:
Controller for the 7-entry 12-bit setpoint multiplexer. It generates the 3-bit select in one of two ways: manual up/down stepping, or an automatic profile that steps through the entries with a fixed dwell time per entry. It reads back the selected 12-bit setpoint and drives a slew-rate-limited setpoint to the regulator loop, so a select change never causes a step in the loop reference.

Parameters:
NUM_SP, 7, number of valid mux entries; valid select values are 0..NUM_SP-1.
DWELL_CYCLES, 100000000, clock cycles the auto mode holds each entry after reaching its target.
SLEW_DIV, 1000, clock cycles between slew ticks.
SLEW_STEP, 8, maximum change in sp_out per slew tick, in LSB.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
btn_up  in  1  single-cycle pulse, already synchronized and debounced; step select up.
btn_down  in  1  single-cycle pulse, already synchronized and debounced; step select down.
auto_en  in  1  level input; 1 selects auto profile mode.
hold  in  1  level input; freezes the ramp and the dwell counter.
sp_mux  in  12  setpoint returned from the mux output.
sel  out  3  select driven to the mux.
sp_out  out  12  slew-limited setpoint to the regulator.
at_target  out  1  1 when sp_out equals the latched target.
ramp_busy  out  1  equal to NOT at_target.

Behaviour:
- Reset (rst_n=0 at a clk edge) applies the following:
  - sel=0, sp_out=0, target_q=0, dwell and slew counters=0, FSM in S_MANUAL.
  - at_target=1 and ramp_busy=0 during reset.
  - Reset mid-ramp abandons the ramp immediately.
- Target latch: target_q <= sp_mux every cycle. Latency from a sel change to the new target_q is 1 cycle.
- FSM states:
  - S_MANUAL: entered when auto_en=0.
  - S_AUTO_RAMP: entered when auto_en=1 and at_target=0.
  - S_AUTO_DWELL: entered when auto_en=1 and at_target=1.
  - An auto_en change takes effect on the next cycle and clears the dwell counter.
- S_MANUAL select rules:
  - btn_up: sel <= sel+1, saturating at NUM_SP-1.
  - btn_down: sel <= sel-1, saturating at 0.
  - btn_up and btn_down in the same cycle: no change.
  - sel updates 1 cycle after the pulse.
- S_AUTO_RAMP:
  - Buttons are ignored.
  - The dwell counter is held at 0.
  - Moves to S_AUTO_DWELL on the cycle at_target=1.
- S_AUTO_DWELL:
  - Buttons are ignored.
  - The dwell counter increments each cycle while hold=0.
  - At count DWELL_CYCLES-1: sel advances with wrap (NUM_SP-1 -> 0), the counter clears, and the FSM goes to S_AUTO_RAMP.
  - If the target changes externally (at_target drops), the FSM returns to S_AUTO_RAMP and the counter clears.
- sel never takes a value >= NUM_SP.
- Slew engine:
  - A tick counter runs 0..SLEW_DIV-1 continuously and is frozen while hold=1.
  - On the terminal count: if sp_out<target_q, then sp_out += min(SLEW_STEP, target_q-sp_out); if sp_out>target_q, then sp_out -= min(SLEW_STEP, sp_out-target_q).
  - Differences are computed at 13 bits. No overflow or underflow is possible, and sp_out never overshoots target_q.
- Target change mid-ramp: the ramp redirects toward the new target_q from the current sp_out. There is no restart.
- hold=1:
  - sp_out, the tick counter and the dwell counter freeze.
  - Manual select changes are still accepted, and target_q still follows.
  - On release, the ramp resumes from the frozen values.
- at_target is combinational: (sp_out==target_q).

Decomposition:
- Shared package constants:
  - FSM state encodings S_MANUAL=2'd0, S_AUTO_RAMP=2'd1, S_AUTO_DWELL=2'd2.
  - Setpoint width SP_W=12.
  - Select width SEL_W=3.
- One sub-module: slew_limiter. Inputs: clk, rst_n, hold, target_q. Outputs: sp_out, at_target. It contains the tick counter and the saturating step logic.
- The FSM and select logic stay in the top module.

Test Plan:
All scenarios use SLEW_DIV=4, SLEW_STEP=8, DWELL_CYCLES=20, NUM_SP=7. The mux model is entry k = 100+50k.
1. Reset release, sp_mux=100 -> sp_out rises by 8 every 4 cycles: 12 steps to 96, then a step of 4 to 100. at_target=1 at the final step; ramp_busy=0 thereafter.
2. Manual mode, 3 btn_up pulses -> sel=3. 5 more pulses -> sel saturates at 6. 10 btn_down pulses -> sel=0. btn_up and btn_down in the same cycle -> sel unchanged.
3. sp_out=300 settled, btn_down changes the target to 250 -> sp_out goes 292, 284 ... 252, then 250 (last step 2). It never passes below 250.
4. auto_en=1 from sel=5 settled -> after 20 dwell cycles sel=6. The ramp to 400 runs, then 20 dwell cycles, then sel wraps to 0. Buttons pulsed during this sequence have no effect.
5. hold=1 mid-ramp at sp_out=180 -> sp_out stays 180 for 50 cycles. btn_up during hold updates sel and target_q only. Release -> the ramp resumes toward the new target.
6. rst_n=0 for 1 cycle mid-ramp at sel=4, sp_out=220 -> the next cycle shows sel=0, sp_out=0, state S_MANUAL. The ramp then proceeds toward 100.
